// File: rtl/demux_pkg.sv
// Shared constants and types for the serial 1:8 demultiplexer.
package demux_pkg;

  localparam int FRAME_BITS_C = 8;
  localparam int SEL_W        = 3;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Index of the final bit of a frame; reaching it closes the frame.
  function automatic logic [SEL_W-1:0] last_sel();
    return SEL_W'(FRAME_BITS_C - 1);
  endfunction

endpackage

// File: rtl/demux1_8.sv
// One-hot 3-to-8 decoder producing per-bit write enables, gated by accept.
module demux1_8
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0]        sel,
  input  logic                    en,
  output logic [FRAME_BITS_C-1:0] we
);

  // Decode the destination index into a single write enable when enabled.
  always_comb begin
    we = 8'h00;
    if (en) begin
      case (sel)
        3'd0:    we = 8'b0000_0001;
        3'd1:    we = 8'b0000_0010;
        3'd2:    we = 8'b0000_0100;
        3'd3:    we = 8'b0000_1000;
        3'd4:    we = 8'b0001_0000;
        3'd5:    we = 8'b0010_0000;
        3'd6:    we = 8'b0100_0000;
        3'd7:    we = 8'b1000_0000;
        default: we = 8'h00;
      endcase
    end else begin
      we = 8'h00;
    end
  end

endmodule

// File: rtl/serial_demux8.sv
// Serial-to-parallel 1:8 demultiplexer: fills an 8-bit frame one accepted
// bit at a time, then holds it until the consumer takes it.
module serial_demux8
  import demux_pkg::*;
#(
  parameter int FRAME_BITS = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_bit,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    clear,
  output logic [FRAME_BITS_C-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        sel_cnt
);

  // Only the 8-bit frame is implemented; any other width must stop elaboration.
  generate
    if (FRAME_BITS != FRAME_BITS_C) begin : g_bad_frame_bits
      $error("serial_demux8: FRAME_BITS must be 8");
    end
  endgenerate

  state_t                  state_r;
  state_t                  state_nx;
  logic [SEL_W-1:0]        sel_r;
  logic [SEL_W-1:0]        sel_nx;
  logic [FRAME_BITS_C-1:0] data_r;
  logic [FRAME_BITS_C-1:0] data_nx;
  logic                    accept_s;
  logic [FRAME_BITS_C-1:0] we_s;

  // Handshake flags come straight from the state so they never glitch on inputs.
  assign in_ready  = (state_r == FILL);
  assign out_valid = (state_r == HOLD);
  assign out_data  = data_r;
  assign sel_cnt   = sel_r;

  // Clear outranks an accept, so a bit presented alongside clear is dropped.
  assign accept_s = in_valid && in_ready && !clear;

  demux1_8 u_dec (
    .sel (sel_r),
    .en  (accept_s),
    .we  (we_s)
  );

  // Next-state, next-index and next-frame computation.
  always_comb begin
    state_nx = state_r;
    sel_nx   = sel_r;
    data_nx  = data_r;

    for (int i = 0; i < FRAME_BITS_C; i++) begin
      if (we_s[i]) begin
        data_nx[i] = in_bit;
      end else begin
        data_nx[i] = data_r[i];
      end
    end

    if (clear) begin
      state_nx = FILL;
      sel_nx   = 3'd0;
    end else begin
      case (state_r)
        FILL: begin
          if (accept_s) begin
            if (sel_r == last_sel()) begin
              sel_nx   = 3'd0;
              state_nx = HOLD;
            end else begin
              sel_nx   = sel_r + 3'd1;
            end
          end else begin
            sel_nx = sel_r;
          end
        end
        HOLD: begin
          // Releasing the frame costs one bubble: no bit is taken this cycle.
          if (out_ready) begin
            state_nx = FILL;
          end else begin
            state_nx = HOLD;
          end
        end
        default: begin
          state_nx = FILL;
          sel_nx   = 3'd0;
        end
      endcase
    end
  end

  // All block state: async reset discards any partial or held frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= FILL;
      sel_r   <= 3'd0;
      data_r  <= 8'h00;
    end else begin
      state_r <= state_nx;
      sel_r   <= sel_nx;
      data_r  <= data_nx;
    end
  end

endmodule

// File: tb/tb_serial_demux8.sv
// Directed self-checking bench for serial_demux8.
module tb_serial_demux8;

  logic       clk;
  logic       reset_n;
  logic       in_bit;
  logic       in_valid;
  logic       in_ready;
  logic       clear;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] sel_cnt;

  int n_checks;
  int n_fail;

  serial_demux8 #(.FRAME_BITS(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .clear     (clear),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_cnt   (sel_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one bit with in_valid high for a single edge.
  task automatic send_bit(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] frame_a;
    logic [7:0] v;
    n_checks  = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    in_bit    = 1'b0;
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #3;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_sel", 32'(sel_cnt), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'h00);
    #9 reset_n = 1'b1;

    // Frame 1,0,1,1,0,0,1,0 -> bit k at out_data[k] -> 8'h4D
    frame_a = 8'b0100_1101;
    for (int k = 0; k < 8; k++) begin
      send_bit(frame_a[k]);
      if (k < 7) begin
        check_eq("fill_sel", 32'(sel_cnt), 32'(k + 1));
        check_eq("fill_no_valid", 32'(out_valid), 32'd0);
      end
    end
    check_eq("f1_valid", 32'(out_valid), 32'd1);
    check_eq("f1_data", 32'(out_data), 32'h4D);
    check_eq("f1_sel_wrap", 32'(sel_cnt), 32'd0);

    // Hold with out_ready low while in_bit toggles: nothing accepted
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_bit = c[0];
      tick();
      check_eq("hold_ready", 32'(in_ready), 32'd0);
      check_eq("hold_data", 32'(out_data), 32'h4D);
      check_eq("hold_sel", 32'(sel_cnt), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("release_ready", 32'(in_ready), 32'd1);
    check_eq("release_valid", 32'(out_valid), 32'd0);
    check_eq("release_data_kept", 32'(out_data), 32'h4D);

    // All ones with a gap cycle before every bit
    for (int k = 0; k < 8; k++) begin
      tick();
      check_eq("gap_hold_sel", 32'(sel_cnt), 32'(k));
      send_bit(1'b1);
      if (k < 7) begin
        check_eq("gap_not_sooner", 32'(out_valid), 32'd0);
      end
    end
    check_eq("gap_valid", 32'(out_valid), 32'd1);
    check_eq("gap_data", 32'(out_data), 32'hFF);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Three bits, then clear with a competing bit; data FF -> FB after bits 1,1,0
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    check_eq("pre_clear_sel", 32'(sel_cnt), 32'd3);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check_eq("clear_sel", 32'(sel_cnt), 32'd0);
    check_eq("clear_data", 32'(out_data), 32'hFB);
    check_eq("clear_ready", 32'(in_ready), 32'd1);
    frame_a = 8'hAA;
    for (int k = 0; k < 8; k++) begin
      send_bit(frame_a[k]);
    end
    check_eq("post_clear_valid", 32'(out_valid), 32'd1);
    check_eq("post_clear_data", 32'(out_data), 32'hAA);

    // Clear while holding discards the frame
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("clear_hold_valid", 32'(out_valid), 32'd0);
    check_eq("clear_hold_data", 32'(out_data), 32'hAA);

    // Refill to HOLD, then pulse reset between edges
    for (int k = 0; k < 8; k++) begin
      send_bit(1'b1);
    end
    check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_rst_valid", 32'(out_valid), 32'd0);
    check_eq("async_rst_data", 32'(out_data), 32'h00);
    check_eq("async_rst_sel", 32'(sel_cnt), 32'd0);
    check_eq("async_rst_ready", 32'(in_ready), 32'd1);
    #1 reset_n = 1'b1;

    // Every frame value back-to-back with out_ready held high
    out_ready = 1'b1;
    for (int f = 0; f < 256; f++) begin
      v = 8'(f);
      check_eq("exh_start_ready", 32'(in_ready), 32'd1);
      for (int k = 0; k < 8; k++) begin
        in_valid = 1'b1;
        in_bit   = v[k];
        tick();
      end
      check_eq("exh_valid", 32'(out_valid), 32'd1);
      check_eq("exh_data", 32'(out_data), 32'(v));
      // Bubble cycle: bit offered but must not be taken
      in_bit = ~v[0];
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_eq("exh_end_sel", 32'(sel_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
